cpu_wr_fifo_p: RTL

//  Parametrised CPU write buffer for the SVGA memory path. It queues host

---
 rtl/cpu_wr_fifo_p.sv | 116 +++++++++++
 1 files changed

// File: rtl/cpu_wr_fifo_p.sv
// CPU write buffer: DEPTH-entry FIFO with same-address merge, drained in req/gnt/ack bursts; fall-through head.
// A written entry raises cpu_wr_req one cycle later; when full, non-merging writes are dropped and flag sticky ff_ovfl.
module cpu_wr_fifo_p #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 20,
  parameter int DEPTH     = 8,
  parameter int MAX_BURST = 4,
  parameter int AFULL_LVL = 6,
  parameter int BE_W      = DATA_W / 8,
  parameter int CW        = $clog2(DEPTH) + 1
) (
  input  logic              mem_clk,
  input  logic              hreset,
  input  logic              g_memwr,
  input  logic              cpu_rd_gnt,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [BE_W-1:0]   wr_be,
  input  logic              cpu_wr_gnt,
  input  logic              crt_req,
  input  logic              svga_ack,
  output logic              cpu_wr_req,
  output logic              cpu_wr_svga_req,
  output logic [ADDR_W-1:0] cpuwr_mem_addr,
  output logic [DATA_W-1:0] cpuwr_mem_data_out,
  output logic [BE_W-1:0]   cpuwr_mwe_n,
  output logic              m_cpu_ff_full,
  output logic              ff_afull,
  output logic              ff_empty,
  output logic [CW-1:0]     ff_count,
  output logic              ff_ovfl
);

  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, XFER} state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
  logic [BE_W-1:0]   be_mem   [DEPTH];
  logic [PW-1:0]     wptr, rptr, tail;
  logic [CW-1:0]     count, count_nxt, bcnt;
  logic              full, push, pop, merge, alloc, drop;

  assign full  = (count == CW'(DEPTH));
  assign push  = g_memwr & ~cpu_rd_gnt;
  assign pop   = svga_ack & (state == XFER);
  assign tail  = wptr - PW'(1);

  // The head entry is frozen while it is being presented to memory, so no merge into it then.
  assign merge = push && (count != '0) && (wr_addr == addr_mem[tail]) &&
                 !((state == XFER) && (tail == rptr));
  assign alloc = push & ~merge & (~full | pop);
  assign drop  = push & ~merge & full & ~pop;
  assign count_nxt = count + CW'(alloc) - CW'(pop);

  always_ff @(posedge mem_clk) begin
    if (alloc) begin
      addr_mem[wptr] <= wr_addr;
      data_mem[wptr] <= wr_data;
      be_mem[wptr]   <= wr_be;
    end else if (merge) begin
      be_mem[tail] <= be_mem[tail] | wr_be;
      for (int b = 0; b < BE_W; b++) begin
        if (wr_be[b]) data_mem[tail][b*8 +: 8] <= wr_data[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge mem_clk) begin
    if (hreset) begin
      wptr    <= '0;
      rptr    <= '0;
      count   <= '0;
      bcnt    <= '0;
      ff_ovfl <= 1'b0;
      state   <= IDLE;
    end else begin
      if (alloc) wptr <= wptr + PW'(1);
      if (pop)   rptr <= rptr + PW'(1);
      count <= count_nxt;
      if (drop) ff_ovfl <= 1'b1;
      case (state)
        IDLE: if (count != '0) state <= REQ;
        REQ: begin
          if (cpu_wr_gnt) begin
            state <= XFER;
            bcnt  <= '0;
          end
        end
        XFER: begin
          if (pop) begin
            bcnt <= bcnt + CW'(1);
            if ((count_nxt == '0) || (bcnt + CW'(1) == CW'(MAX_BURST)) || crt_req)
              state <= IDLE;
          end else if (!cpu_wr_gnt) begin
            state <= REQ;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign cpu_wr_req         = (state != IDLE);
  assign cpu_wr_svga_req    = (state == XFER);
  assign cpuwr_mem_addr     = addr_mem[rptr];
  assign cpuwr_mem_data_out = data_mem[rptr];
  assign cpuwr_mwe_n        = ~be_mem[rptr];
  assign m_cpu_ff_full      = full;
  assign ff_afull           = (count >= CW'(AFULL_LVL));
  assign ff_empty           = (count == '0);
  assign ff_count           = count;

endmodule
